// File: rtl/rv_fetch_decode_ctrl.sv
// rv_fetch_decode_ctrl: multi-cycle RV32 fetch/decode/control for R-type ALU ops and LUI
module rv_fetch_decode_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [4:0]  rs_1,
  output logic [4:0]  rs_2,
  output logic [4:0]  rd_0,
  output logic [2:0]  alu_control,
  output logic        write_rb,
  output logic [31:0] writedata,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] instr_count,
  output logic        illegal_instr,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, WAIT, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] instr;
  logic        is_lui;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, alu_code;
  logic        r_ok, lui_ok;
  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign r_ok   = opcode == 7'b0110011 &&
                  ((funct7 == 7'b0000000 && funct3 != 3'b011) ||
                   (funct7 == 7'b0100000 && funct3 == 3'b000));
  assign lui_ok = opcode == 7'b0110111;
  assign alu_code = funct7[5]          ? 3'b001 :
                    funct3 == 3'b000   ? 3'b000 :
                    funct3 == 3'b111   ? 3'b010 :
                    funct3 == 3'b110   ? 3'b011 :
                    funct3 == 3'b100   ? 3'b100 :
                    funct3 == 3'b010   ? 3'b101 :
                    funct3 == 3'b001   ? 3'b110 : 3'b111;
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     state_nxt = run ? WAIT : FETCH;
      WAIT:      state_nxt = imem_valid ? DECODE : WAIT;
      DECODE:    state_nxt = (r_ok || lui_ok) ? EXECUTE : HALT;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = FETCH;
      default:   state_nxt = HALT;
    endcase
  end
  always_comb begin
    imem_req  = state == FETCH && run;
    imem_addr = pc;
    write_rb  = state == WRITEBACK && rd_0 != 5'd0;
    halted    = state == HALT;
  end
  // writedata doubles as the result register: loaded in EXECUTE, held until the next EXECUTE
  always_ff @(posedge clk)
    if (rst) begin
      pc            <= RESET_PC;
      instr         <= '0;
      instr_count   <= '0;
      illegal_instr <= 1'b0;
      writedata     <= '0;
      rs_1          <= '0;
      rs_2          <= '0;
      rd_0          <= '0;
      alu_control   <= '0;
      is_lui        <= 1'b0;
    end else begin
      case (state)
        WAIT: if (imem_valid) instr <= imem_rdata;
        DECODE: begin
          rs_1        <= instr[19:15];
          rs_2        <= instr[24:20];
          rd_0        <= instr[11:7];
          alu_control <= lui_ok ? 3'b000 : alu_code;
          is_lui      <= lui_ok;
          if (!(r_ok || lui_ok)) illegal_instr <= 1'b1;
        end
        EXECUTE: writedata <= is_lui ? {instr[31:12], 12'h000} : alu_result;
        WRITEBACK: begin
          pc          <= pc + 32'(PC_STEP);
          instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rv_fetch_decode_ctrl.sv
// tb_rv_fetch_decode_ctrl: scoreboard bench with a register-bank/ALU model and an imem responder
module tb_rv_fetch_decode_ctrl;
  logic        clk = 0, rst = 1, run = 0, imem_valid = 0;
  logic [31:0] imem_rdata = 0, alu_result;
  logic        imem_req, write_rb, illegal_instr, halted;
  logic [31:0] imem_addr, writedata, pc, instr_count;
  logic [4:0]  rs_1, rs_2, rd_0;
  logic [2:0]  alu_control;

  rv_fetch_decode_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .rs_1(rs_1), .rs_2(rs_2),
    .rd_0(rd_0), .alu_control(alu_control), .write_rb(write_rb), .writedata(writedata),
    .alu_result(alu_result), .pc(pc), .instr_count(instr_count),
    .illegal_instr(illegal_instr), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          rtype;
    logic [2:0]  ctl;
    logic [4:0]  r1, r2;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0, cyc = 0, req_cyc = 0, req_cnt = 0;
  logic [31:0] exp_pc = 0, exp_cnt = 0;
  logic [31:0] regs [32];
  logic [31:0] a, b;

  // datapath model: combinational register-bank read feeding an ALU
  always_comb begin
    a = regs[rs_1];
    b = regs[rs_2];
    case (alu_control)
      3'b000:  alu_result = a + b;
      3'b001:  alu_result = a - b;
      3'b010:  alu_result = a & b;
      3'b011:  alu_result = a | b;
      3'b100:  alu_result = a ^ b;
      3'b101:  alu_result = {31'd0, $signed(a) < $signed(b)};
      3'b110:  alu_result = a << b[4:0];
      default: alu_result = a >> b[4:0];
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      regs    <= '{default: 32'd0};
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
    end else if (write_rb) regs[rd_0] <= writedata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_req) begin
      req_cyc = cyc;
      req_cnt++;
    end
    if (write_rb) begin
      if (sb.size() == 0) chk("unexpected_write_rd", {27'd0, rd_0}, 32'hFFFF_FFFF);
      else begin
        mon_e = sb.pop_front();
        chk("wr_rd", {27'd0, rd_0}, {27'd0, mon_e.rd});
        chk("wr_data", writedata, mon_e.data);
        chk("wr_latency", cyc - req_cyc, 3 + mon_e.lat);
        if (mon_e.rtype) begin
          chk("wr_rs_1", {27'd0, rs_1}, {27'd0, mon_e.r1});
          chk("wr_rs_2", {27'd0, rs_2}, {27'd0, mon_e.r2});
          chk("wr_alu_control", {29'd0, alu_control}, {29'd0, mon_e.ctl});
        end
      end
    end
  end

  task automatic do_instr(input logic [31:0] ins, input int lat, output bit ok);
    ok = 0;
    @(posedge clk); #1 run = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("req_timeout", {31'd0, imem_req}, 32'd1);
      run = 0;
      return;
    end
    chk("imem_addr", imem_addr, exp_pc);
    @(posedge clk);
    repeat (lat - 1) @(posedge clk);
    #1 imem_valid = 1; imem_rdata = ins; run = 0;
    @(posedge clk); #1 imem_valid = 0;
  endtask

  task automatic run_legal(input logic [31:0] ins, input int lat, input logic [4:0] rd,
                           input logic [31:0] data, input bit rtype, input logic [2:0] ctl,
                           input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    bit ok;
    e = '{rd: rd, data: data, rtype: rtype, ctl: ctl, r1: r1, r2: r2, lat: lat};
    if (rd != 0) sb.push_back(e);
    do_instr(ins, lat, ok);
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_pc  = exp_pc + 32'd4;
    exp_cnt = exp_cnt + 32'd1;
    chk("pc", pc, exp_pc);
    chk("instr_count", instr_count, exp_cnt);
    chk("rd_hold", {27'd0, rd_0}, {27'd0, rd});
    chk("write_rb_low_after", {31'd0, write_rb}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_write_rb", {31'd0, write_rb}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_sel", {17'd0, rs_1, rs_2, rd_0}, 32'd0);
    chk("rst_alu", {29'd0, alu_control}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 0;

    run_legal(32'h002081B3, 1, 5'd3, 32'd12,         1, 3'b000, 5'd1, 5'd2); // ADD x3
    run_legal(32'h402081B3, 1, 5'd3, 32'hFFFF_FFFE, 1, 3'b001, 5'd1, 5'd2); // SUB x3
    run_legal(32'h123452B7, 3, 5'd5, 32'h1234_5000, 0, 3'b000, 5'd0, 5'd0); // LUI x5, slow imem
    run_legal(32'h0020F233, 1, 5'd4, 32'd5,          1, 3'b010, 5'd1, 5'd2); // AND x4
    run_legal(32'h00209333, 2, 5'd6, 32'd640,        1, 3'b110, 5'd1, 5'd2); // SLL x6
    run_legal(32'h00208033, 1, 5'd0, 32'd0,          1, 3'b000, 5'd1, 5'd2); // ADD x0

    do_instr(32'hFFFF_FFFF, 1, ok);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ill_flag", {31'd0, illegal_instr}, 32'd1);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_pc", pc, exp_pc);
    chk("ill_count", instr_count, exp_cnt);
    n = req_cnt;
    run = 1;
    repeat (10) @(negedge clk);
    chk("halt_no_req", req_cnt, n);
    run = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_pc = 0; exp_cnt = 0;
    @(negedge clk);
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_rd", {27'd0, rd_0}, 32'd0);

    run_legal(32'h402081B3, 1, 5'd3, 32'hFFFF_FFFE, 1, 3'b001, 5'd1, 5'd2);

    @(posedge clk); #1 run = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1; break; end
    end
    chk("wait_req_seen", {31'd0, ok}, 32'd1);
    run = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0; imem_valid = 1; imem_rdata = 32'h002081B3;
    @(posedge clk); #1 imem_valid = 0;
    exp_pc = 0; exp_cnt = 0;
    repeat (6) @(negedge clk);
    chk("stale_pc", pc, 32'd0);
    chk("stale_req", {31'd0, imem_req}, 32'd0);
    chk("stale_count", instr_count, 32'd0);
    chk("stale_rd", {27'd0, rd_0}, 32'd0);

    run_legal(32'h002081B3, 1, 5'd3, 32'd12, 1, 3'b000, 5'd1, 5'd2);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
